// File: rtl/sram_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sram_axi_bridge
// Description : AXI4-Lite slave that serializes single-beat reads and writes
//               into one-cycle ena/wen strobes for the SRAM model, with an
//               optional programmable access delay to emulate slow memory.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_bridge #(
  parameter int DELAY = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  // read address / data channels
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  // write address / data / response channels
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // SRAM model side
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [7:0]  sram_wmask,
  output logic        sram_ena,
  output logic        sram_wen,
  input  logic [31:0] sram_rdata
);

  // Delay is held to the 8-bit counter range so the counter can never wrap.
  localparam int         C_DELAY_INT = (DELAY > 255) ? 255 : ((DELAY < 0) ? 0 : DELAY);
  localparam logic [7:0] C_DELAY     = 8'(C_DELAY_INT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RWAIT  = 3'd1,
    S_RACC   = 3'd2,
    S_RLATCH = 3'd3,
    S_RRESP  = 3'd4,
    S_WWAIT  = 3'd5,
    S_WACC   = 3'd6,
    S_BRESP  = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        w_wr_req;

  // A write needs both AW and W present in the same cycle.
  assign w_wr_req = awvalid && wvalid;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and handshake/strobe outputs; strobes depend on state only.
  always_comb begin
    w_next   = r_state;
    arready  = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    rvalid   = 1'b0;
    bvalid   = 1'b0;
    sram_ena = 1'b0;
    sram_wen = 1'b0;
    case (r_state)
      S_IDLE: begin
        arready = !w_wr_req;
        awready = w_wr_req;
        wready  = w_wr_req;
        if (w_wr_req)     w_next = (C_DELAY != 8'd0) ? S_WWAIT : S_WACC;
        else if (arvalid) w_next = (C_DELAY != 8'd0) ? S_RWAIT : S_RACC;
      end
      S_RWAIT:  if (r_cnt == 8'd1) w_next = S_RACC;
      S_RACC: begin
        sram_ena = 1'b1;
        w_next   = S_RLATCH;
      end
      S_RLATCH: w_next = S_RRESP;
      S_RRESP: begin
        rvalid = 1'b1;
        if (rready) w_next = S_IDLE;
      end
      S_WWAIT:  if (r_cnt == 8'd1) w_next = S_WACC;
      S_WACC: begin
        sram_ena = 1'b1;
        sram_wen = 1'b1;
        w_next   = S_BRESP;
      end
      S_BRESP: begin
        bvalid = 1'b1;
        if (bready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latching, delay countdown and read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 8'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_req) begin
            r_addr  <= awaddr;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            r_cnt   <= C_DELAY;
          end else if (arvalid) begin
            r_addr  <= araddr;
            r_cnt   <= C_DELAY;
          end
        end
        S_RWAIT, S_WWAIT: if (r_cnt != 8'd1) r_cnt <= r_cnt - 8'd1;
        S_RLATCH: r_rdata <= sram_rdata;
        default: ;
      endcase
    end
  end

  assign rdata      = r_rdata;
  assign rresp      = 2'b00;
  assign bresp      = 2'b00;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_wmask = {4'b0000, r_wstrb};

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_bridge
// Description : Directed self-checking bench for sram_axi_bridge with a
//               behavioural SRAM model; DELAY=0 and DELAY=5 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axi_bridge;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // DELAY=0 instance signals
  logic [31:0] araddr = '0;  logic arvalid = 1'b0; logic arready;
  logic [31:0] rdata;        logic [1:0] rresp;    logic rvalid; logic rready = 1'b0;
  logic [31:0] awaddr = '0;  logic awvalid = 1'b0; logic awready;
  logic [31:0] wdata = '0;   logic [3:0] wstrb = '0; logic wvalid = 1'b0; logic wready;
  logic [1:0]  bresp;        logic bvalid;         logic bready = 1'b0;
  logic [31:0] sram_addr, sram_wdata; logic [7:0] sram_wmask;
  logic        sram_ena, sram_wen;
  logic [31:0] sram_rdata = '0;
  logic        scramble = 1'b0;

  // DELAY=5 instance signals (read-only traffic, constant SRAM data)
  logic [31:0] d5_araddr = '0; logic d5_arvalid = 1'b0; logic d5_arready;
  logic [31:0] d5_rdata;       logic [1:0] d5_rresp;    logic d5_rvalid; logic d5_rready = 1'b0;
  logic [31:0] d5_zero32 = '0; logic [3:0] d5_zero4 = '0; logic d5_zero1 = 1'b0;
  logic        d5_awready, d5_wready, d5_bvalid; logic [1:0] d5_bresp;
  logic [31:0] d5_sram_addr, d5_sram_wdata; logic [7:0] d5_sram_wmask;
  logic        d5_sram_ena, d5_sram_wen;
  logic [31:0] d5_sram_rdata = 32'hCAFE_F00D;

  sram_axi_bridge #(.DELAY(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
    .sram_ena(sram_ena), .sram_wen(sram_wen), .sram_rdata(sram_rdata)
  );

  sram_axi_bridge #(.DELAY(5)) u_dut5 (
    .clock(clock), .reset_n(reset_n),
    .araddr(d5_araddr), .arvalid(d5_arvalid), .arready(d5_arready),
    .rdata(d5_rdata), .rresp(d5_rresp), .rvalid(d5_rvalid), .rready(d5_rready),
    .awaddr(d5_zero32), .awvalid(d5_zero1), .awready(d5_awready),
    .wdata(d5_zero32), .wstrb(d5_zero4), .wvalid(d5_zero1), .wready(d5_wready),
    .bresp(d5_bresp), .bvalid(d5_bvalid), .bready(d5_zero1),
    .sram_addr(d5_sram_addr), .sram_wdata(d5_sram_wdata), .sram_wmask(d5_sram_wmask),
    .sram_ena(d5_sram_ena), .sram_wen(d5_sram_wen), .sram_rdata(d5_sram_rdata)
  );

  always #5 clock = ~clock;

  // Word-addressed SRAM model: masked writes, read data valid the cycle after ena.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_word;
  logic [31:0] m_key;
  always @(posedge clock) begin
    m_key = {sram_addr[31:2], 2'b00};
    if (sram_ena && sram_wen) begin
      m_word = mem.exists(m_key) ? mem[m_key] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) m_word[8*b +: 8] = sram_wdata[8*b +: 8];
      mem[m_key] = m_word;
    end
    if (sram_ena && !sram_wen) sram_rdata <= mem.exists(m_key) ? mem[m_key] : 32'h0;
    else if (scramble)         sram_rdata <= $urandom;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  // Full write with bready held high; reports observations, no checking.
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int hs_wait, output logic ar_at_hs, output int b_lat,
                           output int ena_cnt, output logic [7:0] mask_seen,
                           output logic [31:0] data_seen, output logic [31:0] addr_seen,
                           output logic wen_seen, output int overlap);
    hs_wait = 0; ar_at_hs = 1'b0; b_lat = -1; ena_cnt = 0; overlap = 0;
    mask_seen = '0; data_seen = '0; addr_seen = '0; wen_seen = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clock);
    while (!(awready && wready) && hs_wait < 50) begin
      next_cycle(); @(negedge clock); hs_wait++;
    end
    ar_at_hs = arready;
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (sram_ena) begin
        ena_cnt++; mask_seen = sram_wmask; data_seen = sram_wdata;
        addr_seen = sram_addr; wen_seen = sram_wen;
        if (bvalid || rvalid) overlap++;
      end
      if (bvalid && b_lat < 0) b_lat = n;
      next_cycle();
      if (b_lat >= 0) break;
    end
  endtask

  // Full read with rready held high; reports observations, no checking.
  task automatic read_txn(input logic [31:0] a, output int hs_wait, output int r_lat,
                          output int ena_cnt, output logic [31:0] addr_seen,
                          output logic wen_seen, output logic [31:0] data_seen,
                          output logic [1:0] resp_seen, output int overlap);
    hs_wait = 0; r_lat = -1; ena_cnt = 0; overlap = 0;
    addr_seen = '0; wen_seen = 1'b0; data_seen = '0; resp_seen = 2'b11;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge clock);
    while (!arready && hs_wait < 50) begin
      next_cycle(); @(negedge clock); hs_wait++;
    end
    next_cycle();
    arvalid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (sram_ena) begin
        ena_cnt++; addr_seen = sram_addr; wen_seen = sram_wen;
        if (rvalid || bvalid) overlap++;
      end
      if (rvalid && r_lat < 0) begin r_lat = n; data_seen = rdata; resp_seen = rresp; end
      next_cycle();
      if (r_lat >= 0) break;
    end
  endtask

  task automatic test_reset();
    @(posedge clock); @(posedge clock); @(negedge clock);
    n_checks++; if ({rvalid, bvalid, sram_ena, sram_wen} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: got %b expected 0000", {rvalid, bvalid, sram_ena, sram_wen}); end
    n_checks++; if ({rdata, sram_addr, sram_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL rst_data: got %h expected 0", {rdata, sram_addr, sram_wdata}); end
    n_checks++; if ({sram_wmask, rresp, bresp} !== 12'h0) begin
      n_fail++; $display("FAIL rst_mask_resp: got %h expected 0", {sram_wmask, rresp, bresp}); end
    n_checks++; if ({arready, awready, wready, d5_arready} !== 4'b1001) begin
      n_fail++; $display("FAIL rst_ready: got %b expected 1001", {arready, awready, wready, d5_arready}); end
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_read();
    int hw, bl, ec, ov; logic ah, we; logic [7:0] mk; logic [31:0] dt, ad;
    logic [1:0] rs;
    write_txn(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, hw, ah, bl, ec, mk, dt, ad, we, ov);
    n_checks++; if (bl !== 2) begin n_fail++; $display("FAIL wr_blat: got %0d expected 2", bl); end
    n_checks++; if (ec !== 1) begin n_fail++; $display("FAIL wr_ena_cnt: got %0d expected 1", ec); end
    n_checks++; if ({mk, we} !== {8'h0F, 1'b1}) begin
      n_fail++; $display("FAIL wr_mask_wen: got %h/%b expected 0f/1", mk, we); end
    n_checks++; if ({ad, dt} !== {32'h8000_0000, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wr_addr_data: got %h/%h expected 80000000/deadbeef", ad, dt); end
    n_checks++; if ({ah, hw, ov} !== {1'b0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL wr_hs: arready=%b wait=%0d overlap=%0d expected 0/0/0", ah, hw, ov); end
    read_txn(32'h8000_0000, hw, bl, ec, ad, we, dt, rs, ov);
    n_checks++; if (hw !== 0) begin n_fail++; $display("FAIL rd_after_b_wait: got %0d expected 0", hw); end
    n_checks++; if (bl !== 3) begin n_fail++; $display("FAIL rd_rlat: got %0d expected 3", bl); end
    n_checks++; if ({dt, rs} !== {32'hDEAD_BEEF, 2'b00}) begin
      n_fail++; $display("FAIL rd_data: got %h/%b expected deadbeef/00", dt, rs); end
    n_checks++; if ({ec, we, ov} !== {32'd1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rd_strobe: ena=%0d wen=%b overlap=%0d expected 1/0/0", ec, we, ov); end
  endtask

  task automatic test_partial_strobe();
    int hw, bl, ec, ov; logic ah, we; logic [7:0] mk; logic [31:0] dt, ad;
    logic [1:0] rs;
    write_txn(32'h8000_0006, 32'h1122_3344, 4'b0101, hw, ah, bl, ec, mk, dt, ad, we, ov);
    n_checks++; if ({mk, ad} !== {8'h05, 32'h8000_0006}) begin
      n_fail++; $display("FAIL ps_mask_addr: got %h/%h expected 05/80000006", mk, ad); end
    read_txn(32'h8000_0004, hw, bl, ec, ad, we, dt, rs, ov);
    n_checks++; if (dt !== 32'h0022_0044) begin
      n_fail++; $display("FAIL ps_rdata: got %h expected 00220044", dt); end
  endtask

  task automatic test_delay5();
    int ena_at = -1; int ec = 0; int rl = -1; int wr_act = 0;
    logic [31:0] dt = '0; logic [31:0] ad = '0; logic hs;
    d5_araddr = 32'h0000_1233; d5_arvalid = 1'b1; d5_rready = 1'b1;
    @(negedge clock);
    hs = d5_arready;
    next_cycle();
    d5_arvalid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (d5_sram_ena) begin ec++; ena_at = n; ad = d5_sram_addr; end
      if (d5_awready || d5_wready || d5_bvalid || d5_sram_wen) wr_act++;
      if (d5_rvalid && rl < 0) begin rl = n; dt = d5_rdata; end
      next_cycle();
      if (rl >= 0) break;
    end
    n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL d5_arready: got %b expected 1", hs); end
    n_checks++; if ({ena_at, ec} !== {32'd6, 32'd1}) begin
      n_fail++; $display("FAIL d5_ena: at=%0d count=%0d expected 6/1", ena_at, ec); end
    n_checks++; if (rl !== 8) begin n_fail++; $display("FAIL d5_rlat: got %0d expected 8", rl); end
    n_checks++; if ({dt, ad} !== {32'hCAFE_F00D, 32'h0000_1233}) begin
      n_fail++; $display("FAIL d5_data_addr: got %h/%h expected cafef00d/00001233", dt, ad); end
    n_checks++; if ({wr_act, d5_rresp} !== {32'd0, 2'b00}) begin
      n_fail++; $display("FAIL d5_quiet: wr_act=%0d rresp=%b expected 0/00", wr_act, d5_rresp); end
  endtask

  task automatic test_simultaneous();
    int ar_n = -1; int b_n = -1; logic [31:0] dt = '0; logic ar0, aw0;
    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0008; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clock);
    ar0 = arready; aw0 = awready;
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (bvalid && b_n < 0) b_n = n;
      if (arready && ar_n < 0) ar_n = n;
      next_cycle();
      if (ar_n >= 0) begin arvalid = 1'b0; break; end
    end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (rvalid) begin dt = rdata; next_cycle(); break; end
      next_cycle();
    end
    n_checks++; if ({ar0, aw0} !== 2'b01) begin
      n_fail++; $display("FAIL sim_first: arready/awready got %b%b expected 01", ar0, aw0); end
    n_checks++; if ({b_n, ar_n} !== {32'd2, 32'd3}) begin
      n_fail++; $display("FAIL sim_order: b at %0d ar at %0d expected 2/3", b_n, ar_n); end
    n_checks++; if (dt !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sim_rdata: got %h expected deadbeef", dt); end
  endtask

  task automatic test_lone_aw();
    int bad = 0; int b_n = -1; logic acc;
    awaddr = 32'h8000_000C; wdata = 32'h5555_AAAA; wstrb = 4'hF; bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (n == 10) begin awvalid = 1'b0; wvalid = 1'b1; end
      @(negedge clock);
      if (awready || wready) bad++;
      next_cycle();
    end
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clock);
    acc = awready && wready;
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (bvalid && b_n < 0) b_n = n;
      next_cycle();
      if (b_n >= 0) break;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL lone_accept: got %0d accepts expected 0", bad); end
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL lone_both: got %b expected 1", acc); end
    n_checks++; if (b_n !== 2) begin n_fail++; $display("FAIL lone_blat: got %0d expected 2", b_n); end
  endtask

  task automatic test_backpressure();
    int rl = -1; int bad = 0; logic [31:0] saved = '0; logic done_rv, idle_ar;
    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b0;
    @(negedge clock);
    next_cycle();
    arvalid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (rvalid) begin rl = n; saved = rdata; break; end
      next_cycle();
    end
    next_cycle();
    scramble = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (!rvalid || rdata !== saved || sram_ena) bad++;
      next_cycle();
    end
    rready = 1'b1;
    next_cycle();
    scramble = 1'b0;
    @(negedge clock);
    done_rv = rvalid; idle_ar = arready;
    next_cycle();
    n_checks++; if ({rl, saved} !== {32'd3, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL bp_first: lat=%0d data=%h expected 3/deadbeef", rl, saved); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    n_checks++; if ({done_rv, idle_ar} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: rvalid/arready got %b%b expected 01", done_rv, idle_ar); end
  endtask

  task automatic test_reset_wacc();
    int hw, rl, ec, ov; int bad = 0; logic we, in_acc; logic [31:0] ad, dt; logic [1:0] rs;
    awaddr = 32'h8000_0010; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clock);
    next_cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    in_acc = sram_ena && sram_wen;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (in_acc !== 1'b1) begin n_fail++; $display("FAIL rw_in_wacc: got %b expected 1", in_acc); end
    n_checks++; if ({sram_ena, sram_wen, bvalid, sram_addr} !== 35'h0) begin
      n_fail++; $display("FAIL rw_async: ena=%b wen=%b bvalid=%b addr=%h expected 0", sram_ena, sram_wen, bvalid, sram_addr); end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    next_cycle();
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (bvalid || rvalid || sram_ena) bad++;
      next_cycle();
    end
    read_txn(32'h8000_0010, hw, rl, ec, ad, we, dt, rs, ov);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rw_no_resp: got %0d bad cycles expected 0", bad); end
    n_checks++; if ({rl, ec, dt} !== {32'd3, 32'd1, 32'h0}) begin
      n_fail++; $display("FAIL rw_after: lat=%0d ena=%0d data=%h expected 3/1/0", rl, ec, dt); end
  endtask

  task automatic test_reset_rresp();
    int hw, bl, ec, ov; int seen = 0; int bad = 0; logic ah, we; logic [7:0] mk;
    logic [31:0] dt, ad;
    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b0;
    @(negedge clock);
    next_cycle();
    arvalid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (rvalid) begin seen = n; break; end
      next_cycle();
    end
    reset_n = 1'b0;
    #1;
    n_checks++; if (seen !== 3) begin n_fail++; $display("FAIL rr_reach: got %0d expected 3", seen); end
    n_checks++; if ({rvalid, rdata} !== 33'h0) begin
      n_fail++; $display("FAIL rr_async: rvalid=%b rdata=%h expected 0/0", rvalid, rdata); end
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();
    rready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (rvalid || bvalid || sram_ena) bad++;
      next_cycle();
    end
    write_txn(32'h8000_0014, 32'hA5A5_5A5A, 4'hF, hw, ah, bl, ec, mk, dt, ad, we, ov);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rr_no_resp: got %0d bad cycles expected 0", bad); end
    n_checks++; if ({bl, ec, dt} !== {32'd2, 32'd1, 32'hA5A5_5A5A}) begin
      n_fail++; $display("FAIL rr_after: lat=%0d ena=%0d data=%h expected 2/1/a5a55a5a", bl, ec, dt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_delay5();
    test_simultaneous();
    test_lone_aw();
    test_backpressure();
    test_reset_wacc();
    test_reset_rresp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
